// File: rtl/eb2c_pkg.sv
// Shared constants and helpers for the eb2c credit transmitter.
package eb2c_pkg;

    localparam int CREDITS_MAX = 255;

    function automatic int credit_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/eb2c_cnt.sv
// Credit counter and ready generation for eb2c.
// EB2C_ERR_EN adds a sticky overflow flag on port err.
module eb2c_cnt
    import eb2c_pkg::*;
#(
    parameter int CREDITS = 2
)
(
    input  logic clk,
    input  logic reset,
    input  logic fire,
    input  logic credit,
    output logic ready
`ifdef EB2C_ERR_EN
    ,
    output logic err
`endif
);

    localparam int CW = credit_w(CREDITS);
    localparam logic [CW:0] LIMIT = (CW + 1)'(CREDITS);

    logic [CW-1:0] cnt;
    logic [CW:0]   sum;
    logic          over;

    // One spare bit so a return with nothing outstanding is visible
    assign sum  = {1'b0, cnt} - {{CW{1'b0}}, fire}
                + {{CW{1'b0}}, credit};
    assign over = sum > LIMIT;

    assign ready = cnt != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= LIMIT[CW-1:0];
        end else if (over) begin
            cnt <= LIMIT[CW-1:0];
        end else begin
            cnt <= sum[CW-1:0];
        end
    end

`ifdef EB2C_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (over) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/eb2c.sv
// Elastic-to-credit transmitter top level.
// EB2C_ERR_EN exposes the sticky credit-overflow flag err.
module eb2c
    import eb2c_pkg::*;
#(
    parameter int T_0_WIDTH = 8,
    parameter int I_0_WIDTH = 8,
    parameter int CREDITS   = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [T_0_WIDTH-1:0] t_0_data,
    input  logic                 t_0_valid,
    output logic                 t_0_ready,
    output logic [I_0_WIDTH-1:0] i_0_data,
    output logic                 i_0_valid,
    input  logic                 i_0_credit
`ifdef EB2C_ERR_EN
    ,
    output logic                 err
`endif
);

    generate
        if (I_0_WIDTH != T_0_WIDTH) begin : g_bad_width
            $error("eb2c: I_0_WIDTH must equal T_0_WIDTH");
        end
        if (CREDITS < 1 || CREDITS > CREDITS_MAX) begin : g_bad_cred
            $error("eb2c: CREDITS out of range");
        end
    endgenerate

    logic fire;

    assign fire = t_0_valid & t_0_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_0_valid <= 1'b0;
            i_0_data  <= '0;
        end else begin
            i_0_valid <= fire;
            if (fire) begin
                i_0_data <= t_0_data;
            end
        end
    end

    eb2c_cnt #(
        .CREDITS (CREDITS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .fire   (fire),
        .credit (i_0_credit),
        .ready  (t_0_ready)
`ifdef EB2C_ERR_EN
        ,
        .err    (err)
`endif
    );

endmodule

// File: tb/tb_eb2c.sv
// Scoreboard bench for eb2c with CREDITS=2.
// Build with EB2C_ERR_EN to also cover the overflow flag.
module tb_eb2c;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] t_0_data;
    logic       t_0_valid;
    logic       t_0_ready;
    logic [7:0] i_0_data;
    logic       i_0_valid;
    logic       i_0_credit;
`ifdef EB2C_ERR_EN
    logic       err;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    eb2c #(
        .T_0_WIDTH (8),
        .I_0_WIDTH (8),
        .CREDITS   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .t_0_data   (t_0_data),
        .t_0_valid  (t_0_valid),
        .t_0_ready  (t_0_ready),
        .i_0_data   (i_0_data),
        .i_0_valid  (i_0_valid),
        .i_0_credit (i_0_credit)
`ifdef EB2C_ERR_EN
        ,
        .err        (err)
`endif
    );

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Monitor: every link beat must match the oldest accepted beat
    always @(negedge clk) begin
        if (!reset && i_0_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat: got %0h expected none",
                         i_0_data);
            end else begin
                check("beat", {24'd0, i_0_data},
                      {24'd0, q.pop_front()});
            end
        end
    end

    // Drive one cycle; er is the hand-computed t_0_ready
    task automatic step(input logic v, input logic [7:0] d,
                        input logic c, input logic er,
                        input string nm);
        t_0_valid  = v;
        t_0_data   = d;
        i_0_credit = c;
        @(negedge clk);
        check(nm, {31'd0, t_0_ready}, {31'd0, er});
        if (v && er) q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        t_0_valid  = 1'b0;
        t_0_data   = 8'h00;
        i_0_credit = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, t_0_ready}, 32'd1);
        check("rst_valid", {31'd0, i_0_valid}, 32'd0);
        check("rst_data", {24'd0, i_0_data}, 32'd0);
`ifdef EB2C_ERR_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", {31'd0, t_0_ready}, 32'd1);
        check("rel_valid", {31'd0, i_0_valid}, 32'd0);
        check("rel_data", {24'd0, i_0_data}, 32'd0);
        @(posedge clk);
        #1;

        // Burst of three with no returns: third beat stalls
        step(1'b1, 8'h11, 1'b0, 1'b1, "burst0_ready");
        check("lat_valid", {31'd0, i_0_valid}, 32'd1);
        check("lat_data", {24'd0, i_0_data}, 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b1, "burst1_ready");
        step(1'b1, 8'h33, 1'b0, 1'b0, "stall0_ready");
        step(1'b1, 8'h33, 1'b0, 1'b0, "stall1_ready");
        check("stall_valid", {31'd0, i_0_valid}, 32'd0);
        check("stall_data", {24'd0, i_0_data}, 32'h22);

        // One credit: no bypass, usable next cycle
        step(1'b1, 8'h33, 1'b1, 1'b0, "cred_ready");
        step(1'b1, 8'h33, 1'b0, 1'b1, "recov_ready");
        step(1'b0, 8'h00, 1'b0, 1'b0, "recov_cnt0");

        // Refill both credits
        step(1'b0, 8'h00, 1'b1, 1'b0, "refill0");
        step(1'b0, 8'h00, 1'b1, 1'b1, "refill1");
        step(1'b0, 8'h00, 1'b0, 1'b1, "refill2");

        // Credit looped back from i_0_valid: full rate
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), i_0_valid, 1'b1, "steady_ready");
            check("steady_valid", {31'd0, i_0_valid}, 32'd1);
        end
        step(1'b0, 8'h00, i_0_valid, 1'b1, "steady_end");

        // Simultaneous fire and credit at cnt=1
        step(1'b1, 8'hA0, 1'b0, 1'b1, "sim0_ready");
        step(1'b1, 8'hA1, 1'b1, 1'b1, "sim1_ready");
        step(1'b0, 8'h00, 1'b0, 1'b1, "sim_hold");
        step(1'b1, 8'hA2, 1'b0, 1'b1, "sim2_ready");
        step(1'b0, 8'h00, 1'b0, 1'b0, "sim_empty");
        step(1'b0, 8'h00, 1'b1, 1'b0, "sim_ref0");
        step(1'b0, 8'h00, 1'b1, 1'b1, "sim_ref1");
`ifdef EB2C_ERR_EN
        check("pre_ovf_err", {31'd0, err}, 32'd0);
`endif

        // Overflow while full: count saturates at 2
        step(1'b0, 8'h00, 1'b1, 1'b1, "ovf_ready");
`ifdef EB2C_ERR_EN
        check("ovf_err", {31'd0, err}, 32'd1);
`endif
        step(1'b1, 8'hB0, 1'b0, 1'b1, "sat0_ready");
        step(1'b1, 8'hB1, 1'b0, 1'b1, "sat1_ready");
        step(1'b0, 8'h00, 1'b0, 1'b0, "sat_stall");
`ifdef EB2C_ERR_EN
        check("err_sticky", {31'd0, err}, 32'd1);
`endif

        // Reset mid-operation with a beat on the link
        step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_cred");
        step(1'b1, 8'hC0, 1'b0, 1'b1, "pre_rst_fire");
        reset = 1'b1;
        q.delete();
        #1;
        check("mid_rst_ready", {31'd0, t_0_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, i_0_valid}, 32'd0);
        check("mid_rst_data", {24'd0, i_0_data}, 32'd0);
`ifdef EB2C_ERR_EN
        check("mid_rst_err", {31'd0, err}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'hD0, 1'b0, 1'b1, "post0_ready");
        step(1'b1, 8'hD1, 1'b0, 1'b1, "post1_ready");
        step(1'b0, 8'h00, 1'b0, 1'b0, "post_stall");
        check("drain", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
